// File: rtl/act_loader.sv
// act_loader: streams a layer's quantized vectors from the PPU output RAM, tagged with the latched scale factor.
module act_loader #(
    parameter int LANES = 16,
    parameter int QW    = 4,
    parameter int SFW   = 40,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [AW:0]          i_num_vec,
    input  logic [SFW*LANES-1:0] i_sf_data,
    input  logic                 i_sf_valid,
    output logic                 o_ram_re,
    output logic [AW-1:0]        o_ram_addr,
    input  logic [QW*LANES-1:0]  i_ram_data,
    output logic [QW*LANES-1:0]  o_act_data,
    output logic [SFW*LANES-1:0] o_act_sf,
    output logic                 o_act_valid,
    input  logic                 i_act_ready,
    output logic                 o_act_last,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int DW = QW*LANES;
    localparam int SW = SFW*LANES;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   sf_q;
    logic            sf_seen;
    logic [AW:0]     num_vec, rd_cnt, beat_cnt;
    logic            pend;
    logic [DW-1:0]   mem [2];
    logic            wp, rp;
    logic [1:0]      cnt;
    logic [1:0]      used;
    logic            err_q, start_ok, pop, re, last;

    assign start_ok = i_start && sf_seen && i_num_vec != '0 && i_num_vec <= (AW+1)'(DEPTH);
    assign pop      = cnt != 2'd0 && i_act_ready;
    assign last     = cnt != 2'd0 && beat_cnt == num_vec - 1'b1;
    // credit counts the slot freed by a same-cycle pop so a steady stream runs at one beat per cycle
    assign used     = cnt - 2'(pop) + 2'(pend);

    always_comb begin
        state_nx = state;
        re       = 1'b0;
        case (state)
            IDLE:  state_nx = start_ok ? FETCH : IDLE;
            FETCH: begin
                re       = used < 2'd2 && rd_cnt < num_vec;
                state_nx = (re && rd_cnt == num_vec - 1'b1) ? DRAIN : FETCH;
            end
            DRAIN: state_nx = (pop && last) ? DONE : DRAIN;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            sf_q     <= '0;
            sf_seen  <= 1'b0;
            num_vec  <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            pend     <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (i_sf_valid) begin
                sf_q    <= i_sf_data;
                sf_seen <= 1'b1;
            end else if (state == DONE) begin
                sf_seen <= 1'b0;
            end
            err_q <= i_start && state == IDLE && !start_ok;
            if (state == IDLE && start_ok) begin
                num_vec  <= i_num_vec;
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (re)  rd_cnt   <= rd_cnt + 1'b1;
                if (pop) beat_cnt <= beat_cnt + 1'b1;
            end
            pend <= re;
            if (pend) begin
                mem[wp] <= i_ram_data;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= used;
        end
    end

    assign o_ram_re    = re;
    assign o_ram_addr  = rd_cnt[AW-1:0];
    assign o_act_data  = mem[rp];
    assign o_act_sf    = sf_q;
    assign o_act_valid = cnt != 2'd0;
    assign o_act_last  = last;
    assign o_busy      = state != IDLE;
    assign o_done      = state == DONE;
    assign o_err       = err_q;
endmodule
